mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU controller's load/store requests. It accepts one request at a time over a level-sampled handshake and converts byte addresses to word addresses. It drives a synchronous single-port word RAM with fixed read latency, performs read-modify-write for byte stores, and returns read data with a one-cycle `done` pulse. It sits between the controller/datapath (`load_addr`/`sel_addr`/`ram_w_en` side) and the instruction/data RAM.

## Interface
- `ADDR_W`, 11, byte-address width; RAM word address is `ADDR_W-2` bits
- `RD_LAT`, 2, RAM read latency in cycles (legal range 1–7)
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req`  in  1  request valid; sampled only in IDLE
- `we`  in  1  1 = store, 0 = load
- `byte_mode`  in  1  1 = byte access (LDRB/STRB), 0 = word
- `addr`  in  ADDR_W  byte address
- `wdata`  in  32  store data; byte stores use `wdata[7:0]`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  misaligned word access; valid while `done`=1
- `rdata`  out  32  load result; held until the next load completes
- `ram_addr`  out  ADDR_W-2  word address = registered `addr[ADDR_W-1:2]`
- `ram_wdata`  out  32  RAM write data
- `ram_w_en`  out  1  RAM write strobe, one cycle per store
- `ram_rdata`  in  32  RAM read data, valid `RD_LAT` edges after `ram_addr` is stable

## Operation
- States: IDLE, RD_WAIT, RMW_RD, WRITE, DONE.
- **IDLE:** on `req`=1, register `we`, `byte_mode`, `addr` and `wdata`, and clear the latency counter. Next state:
  - word access with `addr[1:0]`≠0: DONE with `err`=1; no RAM access
  - load: RD_WAIT
  - word store: WRITE
  - byte store: RMW_RD
- **RD_WAIT:** stays for exactly `RD_LAT` cycles.
  - On the edge ending the last cycle, capture the load result into `rdata`:
    - word load: `ram_rdata`
    - byte load: lane `addr[1:0]`, zero-extended (lane 0 = bits 7:0, little-endian)
  - Then go to DONE.
- **RMW_RD:** stays for `RD_LAT` cycles, then captures `ram_rdata` into the merge register with lane `addr[1:0]` replaced by `wdata[7:0]`. Then go to WRITE.
- **WRITE:** `ram_w_en`=1 for this single cycle.
  - `ram_wdata` is the merged word for byte stores, or the registered `wdata` for word stores.
  - Then go to DONE.
- **DONE:** `done`=1 and `err` reflects the access; next state is IDLE.
- `req` is ignored in every non-IDLE state, including DONE. The requester must hold or re-assert `req` in IDLE.
- Stores never modify `rdata`. Error accesses never modify `rdata` or the RAM.
- `ram_addr` is driven from the registered address and stays stable from the cycle after acceptance until the next acceptance.
- The latency counter is 3 bits wide and saturates at no point; the `RD_LAT`≤7 limit is enforced by an elaboration-time check.

## Timing
- Cycle 0 is the IDLE cycle in which `req`=1 is sampled.
- Word store: WRITE at cycle 1, DONE at cycle 2.
- Load: RD_WAIT at cycles 1..`RD_LAT`, DONE at cycle `RD_LAT`+1. `rdata` is valid from the DONE cycle onward.
- Byte store: RMW_RD at 1..`RD_LAT`, WRITE at `RD_LAT`+1, DONE at `RD_LAT`+2.
- Misaligned word access: DONE with `err`=1 at cycle 1.
- Back-to-back throughput: the next `req` is accepted no earlier than the cycle after DONE.
- `busy`, `done`, `err` and `ram_w_en` are decoded from registered state and are glitch-free.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `err`=0, `rdata`=0, `ram_w_en`=0, `ram_addr`=0, `ram_wdata`=0, counter=0.
- **Reset mid-operation:** the access aborts immediately.
  - `ram_w_en` falls asynchronously with `rst`.
  - No partial write and no `done` are produced.
  - The first request after `rst` deasserts is accepted in the first IDLE cycle.

## Test plan
- **Reset:** assert `rst` in the middle of RMW_RD.
  - Required: all outputs 0 immediately, and no `ram_w_en` pulse through the end of the aborted sequence.
  - Then a word load after reset completes normally.
- **Word store then word load:** `RD_LAT`=2; store `addr`=0x010, `wdata`=0xDEADBEEF.
  - Required: `ram_w_en` at cycle 1 with `ram_addr`=0x004; `done` at cycle 2.
  - Then load `addr`=0x010: `done` at cycle 3 with `rdata`=0xDEADBEEF and `err`=0.
- **Byte load lanes:** RAM word 0x004 = 0x11223344; byte loads from 0x010–0x013.
  - Required: `rdata` = 0x44, 0x33, 0x22, 0x11 respectively, upper 24 bits 0.
- **Byte store merge:** RAM word 0x004 = 0x11223344; STRB `addr`=0x012, `wdata`=0xFFFFFFAB.
  - Required: single `ram_w_en` at cycle `RD_LAT`+1 with `ram_wdata`=0x11AB3344; `done` at `RD_LAT`+2.
- **Misaligned word access:** word load from `addr`=0x011.
  - Required: `done`=1 and `err`=1 at cycle 1, no `ram_w_en`, previous `rdata` unchanged.
  - Repeat for a word store: RAM contents unchanged.
- **Handshake:** hold `req`=1 continuously with alternating load and store.
  - Required: each request is accepted only in IDLE, one `done` per access, `req` is ignored during DONE, and `busy`=0 only in IDLE cycles.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time, drives a single-port
// word RAM with fixed read latency, and merges byte stores via read-modify-write.
module mem_responder #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              byte_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_w_en,
    input  logic [31:0]       ram_rdata
);

    generate
        if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
            $error("mem_responder: RD_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAST = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              byte_q, byte_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [4:0]        lane_lsb;
    logic              misaligned;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        merge_d    = merge_q;
        cnt_d      = cnt_q;
        lane_lsb   = {addr_q[1:0], 3'b000};
        misaligned = !byte_mode && (addr[1:0] != 2'b00);
        case (state_q)
            IDLE: begin
                if (req) begin
                    byte_d  = byte_mode;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 3'd0;
                    err_d   = misaligned;
                    if (misaligned)     state_d = DONE;
                    else if (!we)       state_d = RD_WAIT;
                    else if (byte_mode) state_d = RMW_RD;
                    else                state_d = WRITE;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST) begin
                    rdata_d = byte_q ? {24'd0, ram_rdata[lane_lsb +: 8]} : ram_rdata;
                    state_d = DONE;
                end
            end
            RMW_RD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST) begin
                    merge_d = ram_rdata;
                    merge_d[lane_lsb +: 8] = wdata_q[7:0];
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset clears state first so ram_w_en drops asynchronously with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = (state_q == DONE) && err_q;
    assign ram_w_en  = (state_q == WRITE);
    assign rdata     = rdata_q;
    assign ram_addr  = addr_q[ADDR_W-1:2];
    assign ram_wdata = byte_q ? merge_q : wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus randomized traffic against a
// transaction-level model of memory contents, load results and cycle timing.
module tb_mem_responder;
    localparam int ADDR_W = 11;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, byte_mode = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err, ram_w_en;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_addr;

    mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_mode(byte_mode),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_w_en(ram_w_en), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // RAM: one register stage, so data sampled on the RD_LAT-th edge after the address settles.
    logic [31:0] mem [512];
    logic [31:0] rd_q;
    logic        init_en = 1'b1;
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
        end else if (ram_w_en) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_q <= mem[ram_addr];
    end
    assign ram_rdata = rd_q;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [512];
    logic [31:0] ref_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic b, input logic [10:0] a,
                          input logic [31:0] d, input bit hold);
        int          exp_done, exp_wcyc, c, wcnt, lane;
        logic        bad;
        logic [8:0]  wa;
        logic [31:0] exp_wdata;
        bad       = !b && (a[1:0] != 2'b00);
        wa        = a[10:2];
        lane      = int'(a[1:0]);
        exp_wdata = d;
        exp_wcyc  = -1;
        if (bad)     exp_done = 1;
        else if (!w) exp_done = RD_LAT + 1;
        else if (!b) begin exp_done = 2; exp_wcyc = 1; end
        else begin
            exp_done  = RD_LAT + 2;
            exp_wcyc  = RD_LAT + 1;
            exp_wdata = (ref_mem[wa] & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
        end
        @(posedge clk); #1;
        req = 1'b1; we = w; byte_mode = b; addr = a; wdata = d;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        c = 0; wcnt = 0;
        while (c < 20) begin
            @(posedge clk); #1;
            c++;
            req = hold; we = 1'($urandom); byte_mode = 1'($urandom);
            addr = 11'($urandom); wdata = $urandom;
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            if (!bad) chk("ram_addr", 32'(ram_addr), 32'(wa));
            if (ram_w_en) begin
                wcnt++;
                chk("wen_cycle", 32'(c), 32'(exp_wcyc));
                chk("ram_wdata", ram_wdata, exp_wdata);
            end
            if (done) break;
        end
        chk("done_cycle", 32'(c), 32'(exp_done));
        chk("err", 32'(err), 32'(bad));
        if (!bad) begin
            if (!w) ref_rdata = b ? ((ref_mem[wa] >> (8 * lane)) & 32'hFF) : ref_mem[wa];
            else    ref_mem[wa] = exp_wdata;
        end
        chk("rdata", rdata, ref_rdata);
        chk("wen_count", 32'(wcnt), (exp_wcyc > 0) ? 32'd1 : 32'd0);
        chk("ram_word", mem[wa], ref_mem[wa]);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        ref_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wen", 32'(ram_w_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        init_en = 1'b0;
        rst = 1'b0;

        // Word store then word load, then byte lanes of a known word.
        access(1'b1, 1'b0, 11'h010, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b0, 11'h010, 32'h0, 1'b0);
        chk("word_load_val", rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 11'h010, 32'h11223344, 1'b0);
        for (int i = 0; i < 4; i++) access(1'b0, 1'b1, 11'h010 + 11'(i), 32'h0, 1'b0);
        chk("byte_lane3", rdata, 32'h00000011);
        access(1'b1, 1'b1, 11'h012, 32'hFFFFFFAB, 1'b0);
        chk("merge_word", mem[4], 32'h11AB3344);

        // Misaligned word accesses: no RAM traffic, rdata preserved.
        access(1'b0, 1'b0, 11'h011, 32'h0, 1'b0);
        access(1'b1, 1'b0, 11'h011, 32'hCAFEF00D, 1'b0);

        // Reset in the middle of a byte-store read phase.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; byte_mode = 1'b1; addr = 11'h011; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("rmw_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_wen", 32'(ram_w_en), 32'd0);
        chk("abort_ram_wdata", ram_wdata, 32'd0);
        ref_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_wen", 32'(ram_w_en) | 32'(done), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_ram_word", mem[4], ref_mem[4]);
        access(1'b0, 1'b0, 11'h010, 32'h0, 1'b0);
        chk("post_rst_load", rdata, 32'h11AB3344);

        // req held high with alternating load/store and junk inputs while busy.
        for (int i = 0; i < 30; i++)
            access((i % 2) == 1, 1'($urandom), 11'($urandom_range(0, 63)), $urandom, 1'b1);
        req = 1'b0;
        for (int i = 0; i < 60; i++)
            access(1'($urandom), 1'($urandom), 11'($urandom_range(0, 127)), $urandom, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
